bi_stream_acc: RTL and testbench

- Downstream consumer of the 16-input scaled bipolar MAC's unary output bit oC.
- Counts ones over a fixed window of 2^WIN_LOG2 cycles after a start request.
- Converts the count to a signed bipolar binary value: 2*ones - 2^WIN_LOG2.
- Reports the result with a one-cycle valid pulse, for readback or for the next layer.

---
 rtl/bi_stream_acc.sv | 91 +++++++++
 tb/tb_bi_stream_acc.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/bi_stream_acc.sv
// Bipolar stochastic stream accumulator: counts ones over a 2^WIN_LOG2-cycle window
// and reports 2*ones - 2^WIN_LOG2. Optional BI_STREAM_ACC_UNSCALE_EN shifts the result left by SCALE_LOG2.
module bi_stream_acc #(
    parameter int WIN_LOG2   = 16,
    parameter int SCALE_LOG2 = 4,
`ifdef BI_STREAM_ACC_UNSCALE_EN
    localparam bit UNSCALE   = 1'b1,
`else
    localparam bit UNSCALE   = 1'b0,
`endif
    localparam int SHIFT     = UNSCALE ? SCALE_LOG2 : 0,
    localparam int RES_W     = WIN_LOG2 + 2 + SHIFT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iBit,
    input  logic             start,
    output logic             oBusy,
    output logic             oValid,
    output logic [RES_W-1:0] oResult
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [WIN_LOG2:0]   ones_q, ones_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic [RES_W-1:0]    result_q, result_d;

    logic [WIN_LOG2:0]   ones_inc;
    logic [RES_W-1:0]    bip;

    // ones_inc includes the bit sampled on this edge, so the last sample is counted.
    assign ones_inc = ones_q + (WIN_LOG2+1)'(iBit);
    assign bip      = ((RES_W'(ones_inc) << 1) - (RES_W'(1) << WIN_LOG2)) << SHIFT;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ones_d   = ones_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    ones_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                ones_d = ones_inc;
                cnt_d  = cnt_q + WIN_LOG2'(1);
                if (cnt_q == '1) begin
                    result_d = bip;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ones_q   <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ones_q   <= ones_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign oBusy   = busy_q;
    assign oValid  = valid_q;
    assign oResult = result_q;

endmodule

// File: tb/tb_bi_stream_acc.sv
// Self-checking bench for bi_stream_acc at WIN_LOG2=4; expected results come from
// counting ones in each stimulus window.
module tb_bi_stream_acc;
    localparam int WIN_LOG2   = 4;
    localparam int WIN        = 1 << WIN_LOG2;
    localparam int SCALE_LOG2 = 4;
`ifdef BI_STREAM_ACC_UNSCALE_EN
    localparam int SHIFT = SCALE_LOG2;
`else
    localparam int SHIFT = 0;
`endif
    localparam int RES_W = WIN_LOG2 + 2 + SHIFT;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             iBit = 1'b0;
    logic             start = 1'b0;
    logic             oBusy, oValid;
    logic [RES_W-1:0] oResult;

    int n_chk = 0;
    int n_fail = 0;

    bi_stream_acc #(.WIN_LOG2(WIN_LOG2), .SCALE_LOG2(SCALE_LOG2)) dut (
        .clk(clk), .rst_n(rst_n), .iBit(iBit), .start(start),
        .oBusy(oBusy), .oValid(oValid), .oResult(oResult)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RES_W-1:0] model(input int ones);
        int v;
        v = (2 * ones - WIN) * (1 << SHIFT);
        return RES_W'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full window: start pulse, WIN sampled bits (bit 0 first), one trailing idle cycle.
    task automatic run_window(input string tag, input logic [WIN-1:0] bits, input int extra_start_at);
        logic [RES_W-1:0] exp;
        exp = model($countones(bits));
        start = 1'b1;
        iBit = 1'($urandom);
        tick();
        start = 1'b0;
        check({tag, ".busy_on"}, {30'd0, oBusy, oValid}, 32'd2);
        for (int i = 0; i < WIN; i++) begin
            iBit  = bits[i];
            start = (i == extra_start_at);
            tick();
            if (i < WIN - 1) begin
                if ({oBusy, oValid} !== 2'b10)
                    check($sformatf("%s.run%0d", tag, i), {30'd0, oBusy, oValid}, 32'd2);
            end else begin
                check({tag, ".done"}, {30'd0, oBusy, oValid}, 32'd1);
                check({tag, ".result"}, 32'(oResult), 32'(exp));
            end
        end
        start = 1'b0;
        iBit = 1'($urandom);
        tick();
        check({tag, ".after"}, {30'd0, oBusy, oValid}, 32'd0);
        check({tag, ".hold"}, 32'(oResult), 32'(exp));
    endtask

    initial begin
        int vcyc[$];
        int nv;
        logic [RES_W-1:0] exp16;

        #3;
        check("reset_outputs", {oBusy, oValid, 30'(oResult)}, 32'd0);
        #9 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            iBit = 1'($urandom);
            tick();
        end
        check("idle_no_busy", {30'd0, oBusy, oValid}, 32'd0);

        run_window("all_ones", '1, -1);
        check("all_ones_value", 32'(oResult), 32'(model(WIN)));
        run_window("all_zeros", '0, -1);
        run_window("alternate", 16'h5555, -1);
        run_window("twelve_ones", 16'h0FFF, -1);
        for (int r = 0; r < 4; r++)
            run_window($sformatf("rand%0d", r), WIN'($urandom), -1);
        run_window("start_in_run", 16'h00FF, 5);

        // start held high: back-to-back windows with a one-cycle idle gap
        exp16 = model(WIN);
        start = 1'b1;
        iBit = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (oValid) begin
                vcyc.push_back(c);
                check($sformatf("b2b_result_c%0d", c), 32'(oResult), 32'(exp16));
            end
        end
        start = 1'b0;
        check("b2b_count", vcyc.size(), 2);
        if (vcyc.size() == 2) begin
            check("b2b_first", vcyc[0], 16);
            check("b2b_gap", vcyc[1] - vcyc[0], 17);
        end
        nv = 0;
        while (oBusy && nv < 40) begin
            tick();
            nv++;
        end
        check("b2b_drain", {31'd0, oBusy}, 32'd0);
        tick();

        // reset in the middle of a window discards it
        run_window("pre_reset", '1, -1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            iBit = 1'b1;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset", {oBusy, oValid, 30'(oResult)}, 32'd0);
        tick();
        #2 rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            iBit = 1'b1;
            tick();
            if (oValid || oBusy) nv++;
        end
        check("no_valid_after_reset", nv, 0);
        run_window("post_reset", 16'hF0F7, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish, expected finish before 50000");
        $fatal(1, "timeout");
    end
endmodule
